ahb_bus_decoder_mux: RTL
========================

# ahb_bus_decoder_mux

Parametrised AHB-Lite interconnect back end: decodes the address phase into one-hot slave selects for `SLV_NUM` slaves and registers the data-phase owner. Multiplexes the selected slave's HRDATA/HREADYOUT/HRESP back to the single master. Unmapped active transfers go to a built-in default slave that gives the AHB two-cycle ERROR response and logs the failure. Sits between the core's AHB-Lite master port and the peripheral slaves (clint, plic, uart0, spi0, and later additions).

## Interface
Parameters:
- `SLV_NUM`, 4: number of slaves, 1..16.
- `ADDR_WIDTH`, 32: HADDR width.
- `DATA_WIDTH`, 32: HRDATA width.
- `SLV_BASE`, {0x1000_1000, 0x1000_0000, 0x0C00_0000, 0x0200_0000}: packed `SLV_NUM*ADDR_WIDTH`; slot i = base of slave i.
- `SLV_MASK`, {0xFFFF_F000, 0xFFFF_F000, 0xFC00_0000, 0xFFFF_0000}: packed; slave i matches when `(HADDR & MASK_i) == BASE_i`.

Ports:
- `HCLK`  in  1  clock.
- `HRESET`  in  1  asynchronous, active-high reset.
- `HADDR`  in  ADDR_WIDTH  master address.
- `HTRANS`  in  2  master transfer type.
- `HSEL`  out  SLV_NUM  one-hot address-phase slave select.
- `HRDATA_S`  in  SLV_NUM*DATA_WIDTH  packed slave read data, slot i = slave i.
- `HREADYOUT_S`  in  SLV_NUM  slave ready.
- `HRESP_S`  in  SLV_NUM  slave response (1 = ERROR).
- `HRDATA`  out  DATA_WIDTH  read data to master.
- `HREADY`  out  1  bus ready to master and to all slaves' HREADY input.
- `HRESP`  out  1  response to master.
- `err_cnt`  out  8  saturating count of default-slave ERROR responses.
- `err_addr`  out  ADDR_WIDTH  HADDR of the most recent unmapped active transfer.

## Operation
- **Decode (combinational):**
  - `HSEL[i]` is set when slave i matches.
  - When ranges overlap, the lowest index wins, so HSEL is always one-hot or zero.
  - HSEL is not gated by HTRANS. Slaves qualify with HTRANS.
  - No match selects the default slave internally (`dflt_sel`).
- **Data-phase owner:**
  - Register `dsel` holds `SLV_NUM+1` one-hot bits (slaves plus default), plus `dtrans_act` = HTRANS[1].
  - Both load only when `HREADY`=1.
  - They hold while `HREADY`=0.
- **Mux, slave i owns the data phase:**
  - `HRDATA` = slot i.
  - `HREADY` = `HREADYOUT_S[i]`.
  - `HRESP` = `HRESP_S[i]`.
- **Default slave owns the data phase:**
  - `HRDATA` = 0.
  - FSM states:
    - DS_IDLE: HREADY=1, HRESP=0.
    - DS_ERR1: HREADY=0, HRESP=1.
    - DS_ERR2: HREADY=1, HRESP=1.
  - Transitions:
    - DS_IDLE -> DS_ERR1 when HREADY=1, `dflt_sel`=1 and HTRANS is NONSEQ or SEQ.
    - DS_ERR1 -> DS_ERR2 unconditionally.
    - DS_ERR2 -> DS_ERR1 if another unmapped active transfer is presented in that cycle; otherwise -> DS_IDLE.
  - IDLE/BUSY to an unmapped address gets a zero-wait OKAY and leaves the FSM in DS_IDLE.
- **Error log:**
  - On each entry into DS_ERR1, `err_cnt` increments, saturating at 255, and `err_addr` captures HADDR.
- **Master behaviour during DS_ERR1:**
  - The master may change HTRANS (e.g. to IDLE), as AHB permits.
  - The new address phase is sampled in the DS_ERR2 cycle (HREADY=1).

## Timing
- **Reset values:**
  - `dsel` = default slave; `dtrans_act`=0; FSM=DS_IDLE.
  - HREADY=1, HRESP=0, HRDATA=0.
  - err_cnt=0, err_addr=0.
  - HSEL follows HADDR combinationally, including during reset.
- **Decode latency:** zero. HSEL is valid in the same cycle as HADDR.
- **Mux latency:** zero from slave outputs, selected by the registered `dsel`.
- **Unmapped active transfer:**
  - Address phase in cycle N with HREADY=1.
  - N+1: HREADY=0, HRESP=1.
  - N+2: HREADY=1, HRESP=1.
  - err_cnt is updated at the N+1 edge.
- **Back-to-back slave transfers:** slave A's data phase overlaps slave B's address phase. `dsel` switches at the edge where HREADY=1.
- **Wait states:** a slave holding HREADYOUT=0 freezes `dsel`, even if HADDR changes.
- **Reset mid-operation:** reset asserted in DS_ERR1/DS_ERR2 or during a slave wait state returns all outputs to reset values asynchronously. A pending error is dropped and the counter is cleared.

## Test plan
- **Reset check:**
  - Stimulus: assert HRESET mid-sequence.
  - Required: HREADY=1, HRESP=0, HRDATA=0, err_cnt=0, FSM idle. Re-verify after deassertion.
- **Decode sweep:**
  - HADDR=0x0200_0004 -> HSEL=0001.
  - 0x0C00_1000 -> 0010.
  - 0x1000_0008 -> 0100.
  - 0x1000_1FFC -> 1000.
  - 0x2000_0000 -> 0000.
  - With overlapping masks configured, the lower index wins.
- **Read with wait states:**
  - Stimulus: NONSEQ to uart0 with HRDATA_S slot 2=0xA5A5_0001; uart HREADYOUT low for 2 cycles; next address to spi0 held.
  - Required: HREADY low for 2 cycles; HRDATA=0xA5A5_0001 when HREADY rises; `dsel` moves to spi0 one cycle later.
- **Unmapped NONSEQ at 0x2000_0000:**
  - Required: HREADY/HRESP sequence 0/1 then 1/1; err_cnt=1; err_addr=0x2000_0000.
  - IDLE to the same address: OKAY, no count.
- **Back-to-back errors:**
  - Stimulus: unmapped NONSEQ presented again in DS_ERR2, 300 times.
  - Required: ERR1/ERR2 repeats with no DS_IDLE gap; err_cnt saturates at 255.
- **Slave ERROR pass-through:**
  - Stimulus: plic drives HRESP_S[1]=1 with HREADYOUT 0 then 1.
  - Required: HRESP=1 on both cycles; HREADY 0 then 1; err_cnt unchanged.

Source files
------------

// File: rtl/ahb_bus_decoder_mux.sv
// AHB-Lite interconnect back end: one-hot address decode, data-phase response
// multiplexing, and a default slave that answers unmapped active transfers with ERROR.
module ahb_bus_decoder_mux #(
  parameter int SLV_NUM    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h1000_1000, 32'h1000_0000, 32'h0C00_0000, 32'h0200_0000},
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFC00_0000, 32'hFFFF_0000}
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [ADDR_WIDTH-1:0]         HADDR,
  input  logic [1:0]                    HTRANS,
  output logic [SLV_NUM-1:0]            HSEL,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [SLV_NUM-1:0]            HREADYOUT_S,
  input  logic [SLV_NUM-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]         HRDATA,
  output logic                          HREADY,
  output logic                          HRESP,
  output logic [7:0]                    err_cnt,
  output logic [ADDR_WIDTH-1:0]         err_addr
);

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [SLV_NUM-1:0]    match;
  logic                  dflt_sel;
  logic                  trans_act;
  logic                  ds_start;
  logic [SLV_NUM:0]      dsel;
  logic                  dtrans_act;
  ds_state_t             ds_state;
  ds_state_t             ds_state_nxt;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic                  ready_mux;
  logic                  resp_mux;
  logic                  ds_ready;
  logic                  ds_resp;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address phase: decode
  for (genvar i = 0; i < SLV_NUM; i++) begin : g_match
    assign match[i] = (HADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                      == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Keeping only the lowest set bit resolves overlapping ranges to the lowest index.
  assign HSEL      = match & (~match + SLV_NUM'(1));
  assign dflt_sel  = ~|match;
  assign trans_act = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign ds_start  = HREADY && dflt_sel && trans_act;

  // Address -> data phase: owner register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel       <= {1'b1, {SLV_NUM{1'b0}}};
      dtrans_act <= 1'b0;
    end else if (HREADY) begin
      dsel       <= {dflt_sel, HSEL};
      dtrans_act <= HTRANS[1];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ds_state <= DS_IDLE;
    end else begin
      ds_state <= ds_state_nxt;
    end
  end

  always_comb begin
    ds_state_nxt = ds_state;
    case (ds_state)
      DS_IDLE: if (ds_start) ds_state_nxt = DS_ERR1;
      DS_ERR1: ds_state_nxt = DS_ERR2;
      DS_ERR2: ds_state_nxt = ds_start ? DS_ERR1 : DS_IDLE;
      default: ds_state_nxt = DS_IDLE;
    endcase
  end

  // The error states only ever hold an active default-slave data phase.
  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    if (dtrans_act) begin
      ds_ready = (ds_state != DS_ERR1);
      ds_resp  = (ds_state != DS_IDLE);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else if (ds_start) begin
      err_cnt  <= sat_inc8(err_cnt);
      err_addr <= HADDR;
    end
  end

  // Data phase: response mux
  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b0;
    resp_mux  = 1'b0;
    for (int i = 0; i < SLV_NUM; i++) begin
      if (dsel[i]) begin
        rdata_mux = rdata_mux | HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        ready_mux = ready_mux | HREADYOUT_S[i];
        resp_mux  = resp_mux | HRESP_S[i];
      end
    end
  end

  assign HRDATA = dsel[SLV_NUM] ? '0 : rdata_mux;
  assign HREADY = dsel[SLV_NUM] ? ds_ready : ready_mux;
  assign HRESP  = dsel[SLV_NUM] ? ds_resp : resp_mux;

endmodule
